// File: rtl/vga_pattern_gen.sv
// Test-pattern generator sitting behind a VGA timing generator.
// Two-stage pipeline: stage 1 computes the pixel colour from iX/iY and the
// per-frame state, stage 2 blanks it against the delayed data enable.
// Pattern mode, frame counter and bouncing-box position change only at
// frame start (falling edge of iVS).
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX      = 32
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iHS,
    input  logic       iVS,
    input  logic       iDE,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    input  logic [2:0] iMODE,
    output logic       oHS,
    output logic       oVS,
    output logic [3:0] oVGA_R,
    output logic [3:0] oVGA_G,
    output logic [3:0] oVGA_B,
    output logic [7:0] oFRAME_CNT
);

    typedef enum logic {
        MOVE_INC = 1'b0,
        MOVE_DEC = 1'b1
    } dir_t;

    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BOX);
    localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BOX);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic       vs_prev;
    logic [2:0] mode;
    logic [7:0] frame_cnt;
    logic [9:0] box_x, box_y;
    dir_t       dir_x, dir_y;

    logic [9:0] box_x_nxt, box_y_nxt;
    dir_t       dir_x_nxt, dir_y_nxt;

    logic       hs1, vs1, de1;
    logic [3:0] r1, g1, b1;
    logic [3:0] pix_r, pix_g, pix_b;

    logic       frame_start;
    logic [9:0] bar_full;
    logic [2:0] bar;
    logic       on_grid, in_box;

    assign frame_start = ~iVS & vs_prev;
    assign oFRAME_CNT  = frame_cnt;

    // Next box position: bounce off the edges by stepping back from the limit
    always_comb begin
        box_x_nxt = box_x;
        dir_x_nxt = dir_x;
        if (dir_x == MOVE_INC) begin
            if (box_x == X_MAX) begin
                dir_x_nxt = MOVE_DEC;
                box_x_nxt = X_MAX - 10'd2;
            end else begin
                box_x_nxt = box_x + 10'd2;
            end
        end else begin
            if (box_x == 10'd0) begin
                dir_x_nxt = MOVE_INC;
                box_x_nxt = 10'd2;
            end else begin
                box_x_nxt = box_x - 10'd2;
            end
        end

        box_y_nxt = box_y;
        dir_y_nxt = dir_y;
        if (dir_y == MOVE_INC) begin
            if (box_y == Y_MAX) begin
                dir_y_nxt = MOVE_DEC;
                box_y_nxt = Y_MAX - 10'd2;
            end else begin
                box_y_nxt = box_y + 10'd2;
            end
        end else begin
            if (box_y == 10'd0) begin
                dir_y_nxt = MOVE_INC;
                box_y_nxt = 10'd2;
            end else begin
                box_y_nxt = box_y - 10'd2;
            end
        end
    end

    // Pixel colour for the current input pixel under the active mode
    always_comb begin
        bar_full = iX / 10'd80;
        bar      = bar_full[2:0];
        on_grid  = (iX[4:0] == 5'd0) || (iY[4:0] == 5'd0) ||
                   (iX == X_LAST) || (iY == Y_LAST);
        in_box   = ({1'b0, iX} >= {1'b0, box_x}) &&
                   ({1'b0, iX} <  {1'b0, box_x} + 11'(BOX)) &&
                   ({1'b0, iY} >= {1'b0, box_y}) &&
                   ({1'b0, iY} <  {1'b0, box_y} + 11'(BOX));
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (mode)
            3'd0: begin
                // Bar order white..black maps to R=~k[1], G=~k[2], B=~k[0]
                if (bar_full < 10'd8) begin
                    pix_r = {4{~bar[1]}};
                    pix_g = {4{~bar[2]}};
                    pix_b = {4{~bar[0]}};
                end
            end
            3'd1: begin
                pix_r = {4{on_grid}};
                pix_g = {4{on_grid}};
                pix_b = {4{on_grid}};
            end
            3'd2: begin
                pix_r = {4{iX[5] ^ iY[5]}};
                pix_g = {4{iX[5] ^ iY[5]}};
                pix_b = {4{iX[5] ^ iY[5]}};
            end
            3'd3: begin
                pix_r = iX[5:2];
                pix_g = iY[5:2];
                pix_b = frame_cnt[7:4];
            end
            3'd4: begin
                pix_r = {4{in_box}};
                pix_g = {4{in_box}};
                pix_b = '1;
            end
            default: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase
    end

    // Per-frame state: mode latch, frame counter, box motion
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            vs_prev   <= 1'b1;
            mode      <= '0;
            frame_cnt <= '0;
            box_x     <= '0;
            box_y     <= '0;
            dir_x     <= MOVE_INC;
            dir_y     <= MOVE_INC;
        end else begin
            vs_prev <= iVS;
            if (frame_start) begin
                mode      <= iMODE;
                frame_cnt <= frame_cnt + 8'd1;
                box_x     <= box_x_nxt;
                box_y     <= box_y_nxt;
                dir_x     <= dir_x_nxt;
                dir_y     <= dir_y_nxt;
            end
        end
    end

    // Two-stage output pipeline; colour is blanked by the delayed enable
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            de1    <= 1'b0;
            r1     <= '0;
            g1     <= '0;
            b1     <= '0;
            oHS    <= 1'b1;
            oVS    <= 1'b1;
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
        end else begin
            hs1    <= iHS;
            vs1    <= iVS;
            de1    <= iDE;
            r1     <= pix_r;
            g1     <= pix_g;
            b1     <= pix_b;
            oHS    <= hs1;
            oVS    <= vs1;
            oVGA_R <= de1 ? r1 : '0;
            oVGA_G <= de1 ? g1 : '0;
            oVGA_B <= de1 ? b1 : '0;
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter BOX, default 32: moving-box side in pixels; always even.
REQ-004 SHALL have port iVGA_CLK, input, 1: pixel clock, rising edge; the only clock.
REQ-005 SHALL have port iRST, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port iHS, input, 1: horizontal sync from the timing generator, active-low.
REQ-007 SHALL have port iVS, input, 1: vertical sync from the timing generator, active-low.
REQ-008 SHALL have port iDE, input, 1: data enable; high on active pixels.
REQ-009 SHALL have port iX, input, 10: pixel column; valid while iDE=1.
REQ-010 SHALL have port iY, input, 10: pixel row; valid while iDE=1.
REQ-011 SHALL have port iMODE, input, 3: requested pattern.
REQ-012 SHALL have port oHS, output, 1: iHS delayed by 2 cycles.
REQ-013 SHALL have port oVS, output, 1: iVS delayed by 2 cycles.
REQ-014 SHALL have port oVGA_R, output, 4: red.
REQ-015 SHALL have port oVGA_G, output, 4: green.
REQ-016 SHALL have port oVGA_B, output, 4: blue.
REQ-017 SHALL have port oFRAME_CNT, output, 8: frame counter.

Function
REQ-018 SHALL use a fixed latency of 2 cycles from inputs to outputs; oHS, oVS and RGB for a given input cycle SHALL appear together on the same output cycle.
REQ-019 SHALL drive RGB = 0 on every output cycle whose delayed iDE is 0.
REQ-020 SHALL define frame start as the cycle on which iVS is 0 and its value on the previous cycle was 1.
REQ-021 SHALL act on frame start as follows: load the mode register from iMODE, increment the frame counter, and update the box position. iMODE changes at any other time SHALL have no effect until the next frame start.
REQ-022 SHALL make the frame counter 8 bits wide, wrapping from 255 to 0; oFRAME_CNT SHALL equal the frame counter register.
REQ-023 Mode 0, colour bars: bar index k = iX/80 for k = 0..7; colours in order white, yellow, cyan, green, magenta, red, blue, black; each channel SHALL be 4'hF or 4'h0.
REQ-024 Mode 1, grid: white where iX[4:0]=0, iY[4:0]=0, iX=H_ACTIVE-1 or iY=V_ACTIVE-1; black elsewhere.
REQ-025 Mode 2, checkerboard: white where iX[5]^iY[5]=1; black elsewhere.
REQ-026 Mode 3, gradient: R = iX[5:2], G = iY[5:2], B = frame counter [7:4].
REQ-027 Mode 4, bouncing box: white where box_x <= iX < box_x+BOX and box_y <= iY < box_y+BOX; blue (0,0,F) elsewhere.
REQ-028 Box horizontal update at each frame start:
- moving right and box_x = H_ACTIVE-BOX: direction becomes left, box_x = H_ACTIVE-BOX-2.
- moving left and box_x = 0: direction becomes right, box_x = 2.
- otherwise: box_x changes by ±2 in the current direction.
REQ-029 Box vertical update SHALL follow REQ-028 identically, with box_y, V_ACTIVE and up/down in place of box_x, H_ACTIVE and left/right.
REQ-030 Modes 5-7 SHALL output black on active pixels; sync SHALL still be passed through.
REQ-031 Box position SHALL update on every frame start regardless of the active mode.

Reset
REQ-032 While iRST=1 at a clock edge, the block SHALL set: oHS=1, oVS=1, RGB=0, both pipeline stages at those same idle values with DE=0, mode=0, frame counter=0, box_x=0, box_y=0, direction right/down, previous-iVS register=1.
REQ-033 Reset asserted mid-frame SHALL take effect on the next edge. The first frame start after iRST falls SHALL load iMODE and set the frame counter to 1.

Verification
REQ-034 Stimulus: reset for 3 cycles, then 640x480 timing with iMODE=0. Response: pixel (x=85, y=10) outputs (F,F,0) exactly 2 cycles after input; x=639 outputs (0,0,0).
REQ-035 Stimulus: iMODE switched 0->2 mid-frame. Response: rest of the frame stays colour bars; next frame, pixel (32,0) = white and (32,32) = black.
REQ-036 Stimulus: mode 4 from reset, run 304 frames. Response: box_x = 608 after frame 304, 606 after frame 305, direction left.
REQ-037 Stimulus: run 256 frame starts. Response: oFRAME_CNT wraps 255 -> 0.
REQ-038 Stimulus: iDE=0 with mode 1 on blanking cycles. Response: RGB=0; oHS/oVS equal iHS/iVS delayed exactly 2 cycles.
REQ-039 Stimulus: iRST pulsed mid-line with mode 3 active. Response: next cycle oHS=1, oVS=1, RGB=0, oFRAME_CNT=0, mode reverts to 0.
